// File: rtl/regfile_multi_if.sv
// Bus bundle for regfile_multi: clear control, write port and dual read port.
interface regfile_multi_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 4
);
  logic              clr_start;
  logic              busy;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [WIDTH-1:0]  rd_data_a;
  logic [WIDTH-1:0]  rd_data_b;
  logic              rd_valid;

  modport master (
    output clr_start, wr_en, wr_addr, wr_data, rd_en, rd_addr_a, rd_addr_b,
    input  busy, rd_data_a, rd_data_b, rd_valid
  );

  modport slave (
    input  clr_start, wr_en, wr_addr, wr_data, rd_en, rd_addr_a, rd_addr_b,
    output busy, rd_data_a, rd_data_b, rd_valid
  );
endinterface

// File: rtl/regfile_multi.sv
// Parametrised 2-read/1-write register file with sequential clear engine.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to matching reads.
module regfile_multi #(
  parameter int WIDTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 0
) (
  input  logic            clk,
  input  logic            rst,
  regfile_multi_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [WIDTH-1:0]  rd_a_next;
  logic [WIDTH-1:0]  rd_b_next;
  logic              wr_ok;

  // wr_ok also gates the bypass, so a hardwired-zero entry is never forwarded.
  always_comb begin
    wr_ok     = bus.wr_en && !((ZERO_REG != 0) && (bus.wr_addr == '0));
    rd_a_next = mem[bus.rd_addr_a];
    rd_b_next = mem[bus.rd_addr_b];
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && (bus.rd_addr_a == bus.wr_addr)) rd_a_next = bus.wr_data;
    if (wr_ok && (bus.rd_addr_b == bus.wr_addr)) rd_b_next = bus.wr_data;
`else
`endif
    if ((ZERO_REG != 0) && (bus.rd_addr_a == '0)) rd_a_next = '0;
    if ((ZERO_REG != 0) && (bus.rd_addr_b == '0)) rd_b_next = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= CLEAR;
      ptr           <= '0;
      bus.busy      <= 1'b1;
      bus.rd_data_a <= '0;
      bus.rd_data_b <= '0;
      bus.rd_valid  <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          mem[ptr]     <= '0;
          ptr          <= ptr + 1'b1;
          bus.rd_valid <= 1'b0;
          if (ptr == '1) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end
        IDLE: begin
          if (bus.clr_start) begin
            state        <= CLEAR;
            ptr          <= '0;
            bus.busy     <= 1'b1;
            bus.rd_valid <= 1'b0;
          end else begin
            if (wr_ok) mem[bus.wr_addr] <= bus.wr_data;
            if (bus.rd_en) begin
              bus.rd_data_a <= rd_a_next;
              bus.rd_data_b <= rd_b_next;
              bus.rd_valid  <= 1'b1;
            end else begin
              bus.rd_valid  <= 1'b0;
            end
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_multi.sv
// Scoreboard bench for regfile_multi (ZERO_REG=0 and ZERO_REG=1 instances).
module tb_regfile_multi;
  localparam int WIDTH  = 16;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  logic [WIDTH-1:0]   model [DEPTH];
  logic [2*WIDTH-1:0] sb [$];
  logic [2*WIDTH-1:0] last_rd;
  logic [2*WIDTH-1:0] exp_v;

  regfile_multi_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();
  regfile_multi_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus_z ();

  regfile_multi #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .ZERO_REG(0)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  regfile_multi #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut_z (
    .clk(clk), .rst(rst), .bus(bus_z)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.clr_start = 1'b0; bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    bus.wr_addr = '0; bus.wr_data = '0; bus.rd_addr_a = '0; bus.rd_addr_b = '0;
    bus_z.clr_start = 1'b0; bus_z.wr_en = 1'b0; bus_z.rd_en = 1'b0;
    bus_z.wr_addr = '0; bus_z.wr_data = '0; bus_z.rd_addr_a = '0; bus_z.rd_addr_b = '0;
  endtask

  task automatic test_reset();
    int n;
    idle();
    rst = 1'b0;
    tick();
    checks++;
    if (bus.busy !== 1'b1 || bus.rd_valid !== 1'b0 || bus.rd_data_a !== '0 || bus.rd_data_b !== '0) begin
      failures++;
      $display("FAIL reset_state busy=%b valid=%b a=%h b=%h required busy=1 valid=0 a=0 b=0",
               bus.busy, bus.rd_valid, bus.rd_data_a, bus.rd_data_b);
    end
    rst = 1'b1;
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin tick(); n++; end
    checks++;
    if (n != 16) begin
      failures++;
      $display("FAIL reset_busy_cycles got=%0d required=16", n);
    end
    checks++;
    if (bus_z.busy !== 1'b0) begin
      failures++;
      $display("FAIL zero_dut_busy got=%b required=0", bus_z.busy);
    end
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    last_rd = '0;
  endtask

  task automatic test_all_zero(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      bus.rd_en = 1'b1;
      bus.rd_addr_a = ADDR_W'(i);
      bus.rd_addr_b = ADDR_W'(DEPTH - 1 - i);
      sb.push_back({model[i], model[DEPTH - 1 - i]});
      tick();
      checks++;
      if (bus.rd_valid !== 1'b1) begin
        failures++;
        $display("FAIL %s_valid addr=%0d got=%b required=1", tag, i, bus.rd_valid);
      end
      exp_v = sb.pop_front();
      checks++;
      if ({bus.rd_data_a, bus.rd_data_b} !== exp_v || exp_v !== '0) begin
        failures++;
        $display("FAIL %s_data addr=%0d got=%h required=%h", tag, i,
                 {bus.rd_data_a, bus.rd_data_b}, exp_v);
      end
      last_rd = exp_v;
    end
    idle();
  endtask

  task automatic test_write_read();
    bus.wr_en = 1'b1; bus.wr_addr = 4'd5; bus.wr_data = 16'hBEEF;
    model[5] = 16'hBEEF;
    tick();
    idle();
    bus.rd_en = 1'b1; bus.rd_addr_a = 4'd5; bus.rd_addr_b = 4'd5;
    sb.push_back({model[5], model[5]});
    tick();
    idle();
    checks++;
    if (bus.rd_valid !== 1'b1) begin
      failures++;
      $display("FAIL wr_rd_valid got=%b required=1", bus.rd_valid);
    end
    exp_v = sb.pop_front();
    checks++;
    if ({bus.rd_data_a, bus.rd_data_b} !== exp_v) begin
      failures++;
      $display("FAIL wr_rd_data got=%h required=%h", {bus.rd_data_a, bus.rd_data_b}, exp_v);
    end
    last_rd = exp_v;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (bus.rd_valid !== 1'b0 || {bus.rd_data_a, bus.rd_data_b} !== last_rd) begin
        failures++;
        $display("FAIL rd_hold valid=%b data=%h required valid=0 data=%h",
                 bus.rd_valid, {bus.rd_data_a, bus.rd_data_b}, last_rd);
      end
    end
  endtask

  task automatic test_hazard();
    logic [WIDTH-1:0] ea;
    bus.wr_en = 1'b1; bus.wr_addr = 4'd3; bus.wr_data = 16'h1111;
    model[3] = 16'h1111;
    tick();
`ifdef REGFILE_BYPASS_EN
    ea = 16'h2222;
`else
    ea = 16'h1111;
`endif
    bus.wr_en = 1'b1; bus.wr_addr = 4'd3; bus.wr_data = 16'h2222;
    bus.rd_en = 1'b1; bus.rd_addr_a = 4'd3; bus.rd_addr_b = 4'd5;
    sb.push_back({ea, model[5]});
    model[3] = 16'h2222;
    tick();
    idle();
    exp_v = sb.pop_front();
    checks++;
    if (bus.rd_valid !== 1'b1 || {bus.rd_data_a, bus.rd_data_b} !== exp_v) begin
      failures++;
      $display("FAIL hazard_same_cycle valid=%b got=%h required=%h",
               bus.rd_valid, {bus.rd_data_a, bus.rd_data_b}, exp_v);
    end
    bus.rd_en = 1'b1; bus.rd_addr_a = 4'd3; bus.rd_addr_b = 4'd3;
    sb.push_back({model[3], model[3]});
    tick();
    idle();
    exp_v = sb.pop_front();
    checks++;
    if (bus.rd_valid !== 1'b1 || {bus.rd_data_a, bus.rd_data_b} !== exp_v) begin
      failures++;
      $display("FAIL hazard_next_read valid=%b got=%h required=%h",
               bus.rd_valid, {bus.rd_data_a, bus.rd_data_b}, exp_v);
    end
    last_rd = exp_v;
  endtask

  task automatic test_zero_reg();
    logic [WIDTH-1:0] eb;
    bus_z.wr_en = 1'b1; bus_z.wr_addr = 4'd0; bus_z.wr_data = 16'hFFFF;
    tick();
    bus_z.wr_addr = 4'd1; bus_z.wr_data = 16'h5A5A;
    tick();
    idle();
    bus_z.rd_en = 1'b1; bus_z.rd_addr_a = 4'd0; bus_z.rd_addr_b = 4'd1;
    sb.push_back({16'h0000, 16'h5A5A});
    tick();
    exp_v = sb.pop_front();
    checks++;
    if (bus_z.rd_valid !== 1'b1 || {bus_z.rd_data_a, bus_z.rd_data_b} !== exp_v) begin
      failures++;
      $display("FAIL zero_reg_read valid=%b got=%h required=%h",
               bus_z.rd_valid, {bus_z.rd_data_a, bus_z.rd_data_b}, exp_v);
    end
`ifdef REGFILE_BYPASS_EN
    eb = 16'h7777;
`else
    eb = 16'h0000;
`endif
    bus_z.wr_en = 1'b1; bus_z.wr_addr = 4'd0; bus_z.wr_data = 16'hFFFF;
    bus_z.rd_en = 1'b1; bus_z.rd_addr_a = 4'd0; bus_z.rd_addr_b = 4'd0;
    sb.push_back({16'h0000, 16'h0000});
    tick();
    exp_v = sb.pop_front();
    checks++;
    if (bus_z.rd_valid !== 1'b1 || {bus_z.rd_data_a, bus_z.rd_data_b} !== exp_v) begin
      failures++;
      $display("FAIL zero_reg_bypass got=%h required=%h",
               {bus_z.rd_data_a, bus_z.rd_data_b}, exp_v);
    end
    bus_z.wr_addr = 4'd2; bus_z.wr_data = 16'h7777;
    bus_z.rd_addr_a = 4'd0; bus_z.rd_addr_b = 4'd2;
    sb.push_back({16'h0000, eb});
    tick();
    idle();
    exp_v = sb.pop_front();
    checks++;
    if (bus_z.rd_valid !== 1'b1 || {bus_z.rd_data_a, bus_z.rd_data_b} !== exp_v) begin
      failures++;
      $display("FAIL zero_reg_other got=%h required=%h",
               {bus_z.rd_data_a, bus_z.rd_data_b}, exp_v);
    end
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] wa, ra, rb;
    logic [WIDTH-1:0]  wd, ea, eb;
    bit we, re;
    for (int i = 0; i < 60; i++) begin
      we = ($urandom_range(0, 1) == 1);
      re = ($urandom_range(0, 3) != 0);
      wa = ADDR_W'($urandom_range(0, DEPTH - 1));
      ra = ADDR_W'($urandom_range(0, DEPTH - 1));
      rb = ADDR_W'($urandom_range(0, DEPTH - 1));
      wd = WIDTH'($urandom);
      if (i % 8 == 0) begin ra = wa; we = 1'b1; re = 1'b1; end
      bus.wr_en = we; bus.wr_addr = wa; bus.wr_data = wd;
      bus.rd_en = re; bus.rd_addr_a = ra; bus.rd_addr_b = rb;
      if (re) begin
        ea = model[ra];
        eb = model[rb];
`ifdef REGFILE_BYPASS_EN
        if (we && ra == wa) ea = wd;
        if (we && rb == wa) eb = wd;
`endif
        sb.push_back({ea, eb});
      end
      if (we) model[wa] = wd;
      tick();
      if (re) begin
        exp_v = sb.pop_front();
        checks++;
        if (bus.rd_valid !== 1'b1 || {bus.rd_data_a, bus.rd_data_b} !== exp_v) begin
          failures++;
          $display("FAIL b2b_read iter=%0d valid=%b got=%h required=%h", i,
                   bus.rd_valid, {bus.rd_data_a, bus.rd_data_b}, exp_v);
        end
        last_rd = exp_v;
      end else begin
        checks++;
        if (bus.rd_valid !== 1'b0 || {bus.rd_data_a, bus.rd_data_b} !== last_rd) begin
          failures++;
          $display("FAIL b2b_hold iter=%0d valid=%b got=%h required=%h", i,
                   bus.rd_valid, {bus.rd_data_a, bus.rd_data_b}, last_rd);
        end
      end
    end
    idle();
  endtask

  task automatic test_clr_priority();
    int n;
    for (int i = 1; i < DEPTH; i++) begin
      bus.wr_en = 1'b1; bus.wr_addr = ADDR_W'(i); bus.wr_data = 16'hA5A5;
      model[i] = 16'hA5A5;
      tick();
    end
    bus.clr_start = 1'b1;
    bus.wr_en = 1'b1; bus.wr_addr = 4'd7; bus.wr_data = 16'h1234;
    bus.rd_en = 1'b1; bus.rd_addr_a = 4'd7; bus.rd_addr_b = 4'd1;
    tick();
    idle();
    checks++;
    if (bus.busy !== 1'b1 || bus.rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL clr_accept busy=%b valid=%b required busy=1 valid=0", bus.busy, bus.rd_valid);
    end
    bus.rd_en = 1'b1; bus.rd_addr_a = 4'd1; bus.rd_addr_b = 4'd2;
    n = 1;
    while (bus.busy === 1'b1 && n < 40) begin
      tick();
      checks++;
      if (bus.rd_valid !== 1'b0 || {bus.rd_data_a, bus.rd_data_b} !== last_rd) begin
        failures++;
        $display("FAIL clr_read_blocked cycle=%0d valid=%b data=%h required valid=0 data=%h",
                 n, bus.rd_valid, {bus.rd_data_a, bus.rd_data_b}, last_rd);
      end
      if (bus.busy === 1'b1) n++;
    end
    idle();
    checks++;
    if (n != 16) begin
      failures++;
      $display("FAIL clr_busy_cycles got=%0d required=16", n);
    end
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic test_reset_mid_clear();
    int n;
    for (int i = 0; i < DEPTH; i++) begin
      bus.wr_en = 1'b1; bus.wr_addr = ADDR_W'(i); bus.wr_data = WIDTH'(16'hC000 + i);
      tick();
    end
    idle();
    bus.clr_start = 1'b1;
    tick();
    idle();
    for (int k = 0; k < 7; k++) tick();
    rst = 1'b0;
    tick();
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL midclr_busy got=%b required=1", bus.busy);
    end
    rst = 1'b1;
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin tick(); n++; end
    checks++;
    if (n != 16) begin
      failures++;
      $display("FAIL midclr_busy_cycles got=%0d required=16", n);
    end
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    last_rd = '0;
  endtask

  initial begin
    idle();
    test_reset();
    test_all_zero("reset_readback");
    test_write_read();
    test_hazard();
    test_zero_reg();
    test_back_to_back();
    test_clr_priority();
    test_all_zero("clr_readback");
    test_reset_mid_clear();
    test_all_zero("midclr_readback");
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_multi.md
# regfile_multi

Parametrised dual-read, single-write register file for the CS3710 datapath, replacing the fixed 16x16 register file. Adds configurable width/depth, an optional hardwired-zero register, a registered read-valid strobe, and a sequential clear engine. Reset and software clear both zero the array one entry per cycle behind a `busy` flag. Sits between decode (addresses) and the ALU operand latches (`rd_data_a/b`).

## Interface
- `WIDTH`, 16, data word width in bits (≥1)
- `ADDR_W`, 4, address width; `DEPTH = 2**ADDR_W` entries
- `ZERO_REG`, 0, when 1 entry 0 is hardwired zero: writes dropped, reads return 0

- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-low
- `clr_start`  in  1  request full-array clear (accepted only when idle)
- `busy`  out  1  high while clear engine runs; array inaccessible
- `wr_en`  in  1  write strobe
- `wr_addr`  in  ADDR_W  write address
- `wr_data`  in  WIDTH  write data
- `rd_en`  in  1  read strobe, samples both read addresses
- `rd_addr_a`  in  ADDR_W  port A address
- `rd_addr_b`  in  ADDR_W  port B address
- `rd_data_a`  out  WIDTH  port A registered data
- `rd_data_b`  out  WIDTH  port B registered data
- `rd_valid`  out  1  one-cycle pulse: `rd_data_a/b` updated this cycle

## Operation
- Two states: `CLEAR`, `IDLE`. Clear pointer `ptr` is ADDR_W bits.
- `rst`=0 at an edge:
  - state←`CLEAR`, `ptr`←0, `busy`←1.
  - `rd_data_a`←0, `rd_data_b`←0, `rd_valid`←0.
  - Array contents are untouched by reset itself.
- `CLEAR`, each edge:
  - mem[`ptr`]←0, `ptr`←`ptr`+1.
  - When `ptr`==DEPTH-1: state←`IDLE`, `busy`←0, `ptr` wraps to 0.
  - `wr_en`, `rd_en`, `clr_start` are ignored; `rd_valid` stays 0; read data holds.
- `IDLE`:
  - `clr_start`=1: state←`CLEAR`, `ptr`←0, `busy`←1. This has priority over a same-cycle write (write dropped) and read (no `rd_valid`).
  - Otherwise, `wr_en`=1: mem[`wr_addr`]←`wr_data`, except address 0 when `ZERO_REG`=1.
  - Otherwise, `rd_en`=1: `rd_data_a`←mem[`rd_addr_a`], `rd_data_b`←mem[`rd_addr_b`], `rd_valid`←1.
  - Otherwise, `rd_en`=0: read data holds, `rd_valid`←0.
  - `ZERO_REG`=1: any read of address 0 returns 0.
- Same-address read and write in one cycle: result is set by `REGFILE_BYPASS_EN` (see Configuration).
- Ports A and B may address the same entry; both return identical data.

## Timing
- Read latency: 1 cycle (address at edge N, data and `rd_valid` visible after edge N).
- Write takes effect at the edge. A read issued the following cycle returns the new value.
- Clear duration: exactly DEPTH edges.
  - From reset: `rst`=0 at edge R, then with `rst`=1, edges R+1..R+DEPTH clear entries 0..DEPTH-1.
  - `busy` falls at edge R+DEPTH.
  - Holding `rst` low keeps `ptr` at 0 and clears nothing.
- Reset mid-clear restarts from entry 0. Entries already cleared stay 0.
- `clr_start` at edge C: `busy`=1 after C; entries cleared at C+1..C+DEPTH; `busy`=0 after C+DEPTH.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - An IDLE cycle with `wr_en`=1 and `rd_en`=1, where a read address equals `wr_addr`, returns `wr_data` on that port.
  - The bypass is not applied to address 0 when `ZERO_REG`=1.
- Undefined: the same case returns the pre-write (old) array value.
- Default build: undefined.

## Test plan
- Reset clear, WIDTH=16, ADDR_W=4:
  - Pulse `rst`=0 for 1 cycle -> `busy`=1 for exactly 16 cycles.
  - Then read all 16 addresses -> every read returns 0x0000 with `rd_valid` pulses.
- Write/read latency:
  - Write 0xBEEF to r5, next cycle read A=r5, B=r5 -> one cycle later both ports = 0xBEEF, `rd_valid`=1 for one cycle.
  - Hold `rd_en`=0 -> data holds, `rd_valid`=0.
- Same-cycle write/read hazard:
  - Preload r3=0x1111; in one cycle write r3=0x2222 and read A=r3 -> 0x2222 with `REGFILE_BYPASS_EN`, 0x1111 without.
  - Next read -> 0x2222 in both builds.
- `ZERO_REG`=1: write r0=0xFFFF, then read A=r0 -> 0x0000 in both builds.
- `clr_start` priority:
  - Fill r1..r15 with 0xA5A5; assert `clr_start` with `wr_en` to r7=0x1234 -> write dropped, `busy` high 16 cycles.
  - During clear, `rd_en`=1 -> no `rd_valid`; after clear all entries read 0x0000.
- Reset mid-clear:
  - Assert `rst`=0 at clear cycle 8 -> `busy` stays high and clear restarts at entry 0.
  - `busy` falls 16 edges after `rst` returns high; all entries read 0x0000.
